// File: rtl/instruction_fetch.sv
// Instruction fetch stage: fetch PC, single-outstanding imem req/ack,
// FWFT buffer of {instruction, pc} to decode over valid/ready.
// Ports: clk, rst_n; imem_req/addr/ack/rdata; if_valid/ready/instruction/pc;
// redirect/redirect_pc; fetch_fault.
// Optional: define IF_ALIGN_CHECK_EN for a sticky misaligned-redirect fault.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_t;

  state_t          state_q, state_d;
  logic            req_q, req_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic            fault_q, fault_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [31:0]     instr_q [FIFO_DEPTH];
  logic [31:0]     pc_q    [FIFO_DEPTH];

  logic            push;
  logic            pop;
  logic            flush;
  logic            bad;
  logic            stop;
  logic [31:0]     tgt;
  logic [31:0]     pc_inc;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    fetch_pc_d = fetch_pc_q;
    fault_d    = fault_q;
    push       = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;
    tgt        = redirect_pc & ~32'h3;
    pc_inc     = fetch_pc_q + 32'd4;
`ifdef IF_ALIGN_CHECK_EN
    bad        = redirect & (redirect_pc[1:0] != 2'b00);
`else
    bad        = 1'b0;
`endif
    stop       = fault_q | bad;
    fault_d    = fault_q | bad;

    if (redirect) begin
      flush      = 1'b1;
      fetch_pc_d = tgt;
      unique case (state_q)
        IDLE: begin
          if (!stop) begin
            state_d = REQ;
            addr_d  = tgt;
          end
        end
        REQ: begin
          // Unacked request must finish at its old address first.
          if (imem_ack) begin
            state_d = stop ? IDLE : REQ;
            addr_d  = tgt;
          end else begin
            state_d = DROP;
          end
        end
        DROP: begin
          if (imem_ack) begin
            state_d = stop ? IDLE : REQ;
            addr_d  = tgt;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      pop = if_valid & if_ready;
      unique case (state_q)
        IDLE: begin
          if (count_q < CW'(FIFO_DEPTH) && !fault_q) begin
            state_d = REQ;
            addr_d  = fetch_pc_q;
          end
        end
        REQ: begin
          if (imem_ack) begin
            push       = 1'b1;
            fetch_pc_d = pc_inc;
            addr_d     = pc_inc;
            // Same-cycle pop is not credited until next cycle.
            state_d    = (count_q + CW'(1) < CW'(FIFO_DEPTH)) ? REQ : IDLE;
          end
        end
        DROP: begin
          if (imem_ack) begin
            state_d = fault_q ? IDLE : REQ;
            addr_d  = fetch_pc_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    req_d = (state_d != IDLE);

    count_d = count_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    if (flush) begin
      count_d = '0;
      rd_d    = '0;
      wr_d    = '0;
    end else begin
      if (push) wr_d = wr_q + PW'(1);
      if (pop)  rd_d = rd_q + PW'(1);
      if (push && !pop) count_d = count_q + CW'(1);
      if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      fault_q    <= 1'b0;
      count_q    <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
      fault_q    <= fault_d;
      count_q    <= count_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      if (push) begin
        instr_q[wr_q] <= imem_rdata;
        pc_q[wr_q]    <= fetch_pc_q;
      end
    end
  end

  assign imem_req       = req_q;
  assign imem_addr      = addr_q;
  assign if_valid       = (count_q != '0);
  assign if_instruction = if_valid ? instr_q[rd_q] : '0;
  assign if_pc          = if_valid ? pc_q[rd_q] : '0;
  assign fetch_fault    = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch (RESET_PC=0x100, depth 4).
// Memory returns addr + 0x1000_0000 after a programmable wait.
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  int passed;
  int total;
  int lat;
  int cnt;
  int acks;

  instruction_fetch #(
    .RESET_PC  (32'h0000_0100),
    .FIFO_DEPTH(4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instruction(if_instruction),
    .if_pc         (if_pc),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .fetch_fault   (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_ack   = imem_req && (cnt >= lat);
  assign imem_rdata = imem_ack ? (imem_addr + 32'h1000_0000) : 32'h0;

  always @(posedge clk) begin
    if (imem_req && !imem_ack) cnt <= cnt + 1;
    else                       cnt <= 0;
    if (imem_req && imem_ack)  acks <= acks + 1;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    total++;
    if (imem_req !== 1'b0) $display("FAIL rst_req got %b want 0", imem_req);
    else passed++;
    total++;
    if (imem_addr !== 32'h100) $display("FAIL rst_addr got %h want 100", imem_addr);
    else passed++;
    total++;
    if ({if_valid, if_instruction, if_pc} !== 65'h0)
      $display("FAIL rst_if got %b %h %h want 0", if_valid, if_instruction, if_pc);
    else passed++;
    total++;
    if (fetch_fault !== 1'b0) $display("FAIL rst_fault got %b want 0", fetch_fault);
    else passed++;
  endtask

  task automatic test_stream();
    logic [31:0] ea;
    logic [31:0] ep;
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      ea = 32'h100 + 32'(4 * (k - 1));
      total++;
      if (imem_req !== 1'b1 || imem_addr !== ea)
        $display("FAIL stream_addr%0d got %b %h want 1 %h", k, imem_req, imem_addr, ea);
      else passed++;
      if (k >= 2) begin
        ep = 32'h100 + 32'(4 * (k - 2));
        total++;
        if (if_valid !== 1'b1 || if_pc !== ep || if_instruction !== ep + 32'h1000_0000)
          $display("FAIL stream_out%0d got %b %h %h want pc %h", k, if_valid, if_pc,
                   if_instruction, ep);
        else passed++;
      end
    end
  endtask

  task automatic test_backpressure();
    int a0;
    bit seen;
    logic [31:0] ep;
    rst_n    = 1'b0;
    if_ready = 1'b0;
    step();
    rst_n = 1'b1;
    a0 = acks;
    for (int i = 0; i < 10; i++) step();
    total++;
    if (acks - a0 !== 4) $display("FAIL bp_acks got %0d want 4", acks - a0);
    else passed++;
    total++;
    if (imem_req !== 1'b0) $display("FAIL bp_req got %b want 0", imem_req);
    else passed++;
    total++;
    if (if_valid !== 1'b1 || if_pc !== 32'h100)
      $display("FAIL bp_head got %b %h want 1 100", if_valid, if_pc);
    else passed++;
    if_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ep = 32'h100 + 32'(4 * i);
      total++;
      if (if_valid !== 1'b1 || if_pc !== ep || if_instruction !== ep + 32'h1000_0000)
        $display("FAIL bp_drain%0d got %b %h %h want pc %h", i, if_valid, if_pc,
                 if_instruction, ep);
      else passed++;
      if (imem_req && !seen) begin
        seen = 1'b1;
        total++;
        if (imem_addr !== 32'h110) $display("FAIL bp_resume got %h want 110", imem_addr);
        else passed++;
      end
      step();
    end
    total++;
    if (!seen) $display("FAIL bp_resume_seen got 0 want 1");
    else passed++;
  endtask

  task automatic test_redirect_flush();
    if_ready = 1'b0;
    step();
    total++;
    if (if_valid !== 1'b1) $display("FAIL rf_pre got %b want 1", if_valid);
    else passed++;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_2000;
    step();
    redirect = 1'b0;
    total++;
    if (if_valid !== 1'b0) $display("FAIL rf_flush got %b want 0", if_valid);
    else passed++;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h2000)
      $display("FAIL rf_req got %b %h want 1 2000", imem_req, imem_addr);
    else passed++;
    if_ready = 1'b1;
    step();
    total++;
    if (if_valid !== 1'b1 || if_pc !== 32'h2000 || if_instruction !== 32'h1000_2000)
      $display("FAIL rf_first got %b %h %h want 1 2000 10002000", if_valid, if_pc,
               if_instruction);
    else passed++;
  endtask

  task automatic test_drop();
    if_ready = 1'b0;
    for (int i = 0; i < 8; i++) step();
    total++;
    if (imem_req !== 1'b0) $display("FAIL dr_full got %b want 0", imem_req);
    else passed++;
    lat         = 3;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_001C;
    step();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h1C || if_valid !== 1'b0)
      $display("FAIL dr_issue got %b %h %b want 1 1c 0", imem_req, imem_addr, if_valid);
    else passed++;
    redirect_pc = 32'h0000_0400;
    step();
    redirect = 1'b0;
    if_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h1C || if_valid !== 1'b0)
        $display("FAIL dr_hold%0d got %b %h %b want 1 1c 0", i, imem_req, imem_addr,
                 if_valid);
      else passed++;
      step();
    end
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h400 || if_valid !== 1'b0)
      $display("FAIL dr_next got %b %h %b want 1 400 0", imem_req, imem_addr, if_valid);
    else passed++;
    lat = 0;
    step();
    total++;
    if (if_valid !== 1'b1 || if_pc !== 32'h400)
      $display("FAIL dr_first got %b %h want 1 400", if_valid, if_pc);
    else passed++;
  endtask

  task automatic test_wrap();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    total++;
    if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wr_addr got %h want fffffffc", imem_addr);
    else passed++;
    step();
    total++;
    if (imem_addr !== 32'h0 || if_pc !== 32'hFFFF_FFFC)
      $display("FAIL wr_next got %h %h want 0 fffffffc", imem_addr, if_pc);
    else passed++;
    step();
    total++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instruction !== 32'h1000_0000)
      $display("FAIL wr_pc0 got %b %h %h want 1 0 10000000", if_valid, if_pc, if_instruction);
    else passed++;
  endtask

  task automatic test_align();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0402;
    step();
    redirect = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
    total++;
    if (fetch_fault !== 1'b1 || if_valid !== 1'b0)
      $display("FAIL al_fault got %b %b want 1 0", fetch_fault, if_valid);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (imem_req !== 1'b0 || if_valid !== 1'b0 || fetch_fault !== 1'b1)
        $display("FAIL al_quiet%0d got %b %b %b want 0 0 1", i, imem_req, if_valid,
                 fetch_fault);
      else passed++;
    end
`else
    total++;
    if (fetch_fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h400)
      $display("FAIL al_addr got %b %b %h want 0 1 400", fetch_fault, imem_req, imem_addr);
    else passed++;
    step();
    total++;
    if (if_valid !== 1'b1 || if_pc !== 32'h400 || fetch_fault !== 1'b0)
      $display("FAIL al_pc got %b %h %b want 1 400 0", if_valid, if_pc, fetch_fault);
    else passed++;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    passed      = 0;
    total       = 0;
    lat         = 0;
    cnt         = 0;
    acks        = 0;
    rst_n       = 1'b0;
    if_ready    = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_drop();
    test_wrap();
    test_align();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage feeding the SPARC decode stage. Holds the fetch PC, issues word reads to instruction memory over a single-outstanding req/ack handshake, and buffers returned words with their PCs in a small FIFO. Presents them to decode through a valid/ready interface. Accepts redirects (taken branches, resolved by decode after its delay slot) that flush buffered and in-flight instructions.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset; must be word-aligned.
- `FIFO_DEPTH`, default 4: instruction buffer entries; power of 2, ≥2.
- `clk` in 1: system clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: fetch request; held with stable `imem_addr` until acked.
- `imem_addr` out 32: word address of the request; bits [1:0] always 0.
- `imem_ack` in 1: request complete; `imem_rdata` valid in the same cycle.
- `imem_rdata` in 32: fetched instruction word.
- `if_valid` out 1: `if_instruction`/`if_pc` hold a valid entry.
- `if_ready` in 1: decode accepts the entry this cycle.
- `if_instruction` out 32: instruction word to decode.
- `if_pc` out 32: address of `if_instruction`.
- `redirect` in 1: one-cycle pulse; restart fetch at `redirect_pc`.
- `redirect_pc` in 32: redirect target, sampled when `redirect`=1.
- `fetch_fault` out 1: sticky misaligned-redirect flag (see Configuration).

## Operation
- FSM states:
  - IDLE: no request outstanding.
  - REQ: request outstanding; data kept.
  - DROP: request outstanding; data will be discarded.
- IDLE→REQ when `count + 0 < FIFO_DEPTH` and not faulted: assert `imem_req`, `imem_addr`=fetch_pc.
- REQ on `imem_ack`:
  - push {`imem_rdata`, fetch_pc}; fetch_pc += 4, 32-bit wrap.
  - If space remains after the push, stay in REQ with the next address from the next cycle; otherwise go to IDLE.
- Space check: `count` counts FIFO entries; a pop in the same cycle does not grant space until the next cycle.
- Single outstanding request, so the FIFO never overflows.
- FIFO is first-word fall-through:
  - `if_valid` = non-empty.
  - Pop when `if_valid && if_ready`.
  - Push and pop in the same cycle leave `count` unchanged.
- When `if_valid`=0, `if_instruction` and `if_pc` are driven to 0.
- `redirect` has priority over push, pop and state transitions in its cycle:
  - FIFO flushed: count=0, pointers reset, any pop that cycle ignored.
  - fetch_pc ← {`redirect_pc[31:2]`, 2'b00}.
  - From REQ without ack that cycle → DROP; keep `imem_req` and the old `imem_addr` until ack.
  - From REQ with ack that cycle → data discarded, go to REQ at the new PC.
  - From IDLE → REQ.
- DROP on `imem_ack`: discard data, go to REQ at the current fetch_pc.
- `redirect` during DROP: update fetch_pc only, stay in DROP.
- Reset values:
  - `imem_req`=0, `imem_addr`=RESET_PC.
  - `if_valid`=0, `if_instruction`=0, `if_pc`=0.
  - `fetch_fault`=0, FSM=IDLE, count=0, fetch_pc=RESET_PC.
- Reset asserted mid-request abandons the request; instruction memory must tolerate `imem_req` dropping without ack under reset.

## Timing
- First `imem_req` is the first cycle after `rst_n` deasserts.
- Zero-wait memory (`imem_ack` in the cycle `imem_req` is high): pushed entry is visible (`if_valid`=1) the next cycle.
- Throughput is 1 instruction/cycle while the FIFO has space and `if_ready`=1.
- Redirect in cycle N:
  - `if_valid`=0 in N+1.
  - Request for the target in N+1 (from IDLE/REQ).
  - With a zero-wait ack, the target instruction is presented in N+2.
  - From DROP, add the stale request's remaining wait cycles.
- `imem_addr` changes only in the cycle after an ack, a redirect from IDLE, or a DROP completion; never while a request is unacked.

## Configuration
- `IF_ALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[1:0]`≠0 sets `fetch_fault`=1 in the next cycle and flushes the FIFO.
  - An outstanding request completes and is dropped; no new requests are issued.
  - `if_valid` stays 0 until reset.
- Not defined: `fetch_fault` tied to 0; `redirect_pc[1:0]` ignored (forced to 0).

## Test plan
- Reset release, RESET_PC=0x100, zero-wait memory, `if_ready`=1 → addresses 0x100, 0x104, 0x108… on consecutive cycles; `if_pc` follows one cycle later with matching `if_instruction`.
- `if_ready`=0, FIFO_DEPTH=4 → exactly 4 acks, then `imem_req`=0. Raise `if_ready` → 4 entries in order, fetching resumes at 0x110.
- Redirect to 0x2000 while `if_valid`=1 and the FIFO holds 3 entries → `if_valid`=0 next cycle; first presented `if_pc`=0x2000.
- Redirect to 0x400 while a request to 0x1C waits 3 cycles for ack → `imem_addr` stays 0x1C until ack; data dropped; next request 0x400; no entry with `if_pc`=0x1C appears.
- fetch_pc 0xFFFF_FFFC → next request address 0x0000_0000.
- With `IF_ALIGN_CHECK_EN`, redirect to 0x402 → `fetch_fault`=1, no further `imem_req`, `if_valid`=0. Without the macro → fetch at 0x400, `fetch_fault`=0.
